issue_ctrl: RTL and testbench

- Issue-stage sequencer between the instruction decoder and the execute stage.
- Consumes the decoded control pack and resolves RAW hazards against the EXE and MEM stages. It selects the forwarding source for rs1/rs2.
- Serialises multi-cycle MUL/DIV operations.
- Drains the pipeline and pulses a flush for fence.i / flush_pipe instructions.

---
 rtl/issue_ctrl_pkg.sv | 42 ++++
 rtl/issue_ctrl_hazard.sv | 39 +++
 rtl/issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue stage.
//   issue_state_e : issue sequencer states
//   fwd_sel_e     : operand source select encoding
//   decode_pack   : decoded control pack handed over by the decoder
//   stage_occ_t   : occupant summary of a downstream stage (EXE / MEM)
package issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    DRAIN   = 2'd2,
    FLUSH   = 2'd3
  } issue_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  // Source operands checked per instruction (rs1, rs2).
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_en;
    logic       rs2_en;
    logic       mul_en;
    logic       div_en;
    logic       fence_i;
    logic       flush_pipe;
  } decode_pack;

  typedef struct packed {
    logic       vld;
    logic       rd_en;
    logic       fwd;
    logic [4:0] rd;
  } stage_occ_t;

endpackage

// File: rtl/issue_ctrl_hazard.sv
// hazard_fwd_unit: combinational RAW check for one source operand.
//   rs, rs_en : source register and its enable
//   exe, mem  : occupant summary of the EXE and MEM stages
//   fwd_sel   : 0 = regfile, 1 = EXE, 2 = MEM
//   unres     : hazard exists and cannot be covered by forwarding
// EXE is the younger producer, so an EXE match shadows a MEM match.
module hazard_fwd_unit
  import issue_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0] rs,
  input  logic       rs_en,
  input  stage_occ_t exe,
  input  stage_occ_t mem,
  output logic [1:0] fwd_sel,
  output logic       unres
);

  logic need, exe_hit, mem_hit;

  // x0 never carries a dependency.
  assign need    = rs_en && (rs != 5'd0);
  assign exe_hit = exe.vld && exe.rd_en && (exe.rd == rs);
  assign mem_hit = mem.vld && mem.rd_en && (mem.rd == rs);

  always_comb begin
    fwd_sel = FWD_RF;
    unres   = 1'b0;
    if (need && exe_hit) begin
      if (FWD_EN && exe.fwd) fwd_sel = FWD_EXE;
      else                   unres   = 1'b1;
    end else if (need && mem_hit) begin
      if (FWD_EN && mem.fwd) fwd_sel = FWD_MEM;
      else                   unres   = 1'b1;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: issue-stage sequencer between decode and execute.
//   clk, rst_n        : clock, async active-low reset
//   id_valid/id_pack  : decoded instruction and its controls
//   id_illegal        : instruction issues as a trap bubble, no hazard check
//   exe_* / mem_*     : downstream stage occupants for RAW checks
//   exe_ready         : execute stage accepts an instruction
//   md_done           : MUL/DIV result pulse
//   issue_valid       : instruction handed to EXE this cycle
//   id_stall          : hold decoder/fetch registers
//   fwd_rs1/fwd_rs2   : operand source select
//   md_start          : MUL/DIV start pulse (same cycle as issue)
//   flush_req         : one-cycle flush after a fence.i / flush_pipe drains
//   md_err            : sticky MUL/DIV timeout
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter bit FWD_EN     = 1'b1,
  parameter int MD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  decode_pack id_pack,
  input  logic       id_illegal,
  input  logic       exe_valid,
  input  logic       exe_rd_en,
  input  logic       exe_fwd,
  input  logic [4:0] exe_rd,
  input  logic       mem_valid,
  input  logic       mem_rd_en,
  input  logic       mem_fwd,
  input  logic [4:0] mem_rd,
  input  logic       exe_ready,
  input  logic       md_done,
  output logic       issue_valid,
  output logic       id_stall,
  output logic [1:0] fwd_rs1,
  output logic [1:0] fwd_rs2,
  output logic       md_start,
  output logic       flush_req,
  output logic       md_err
);

  localparam int CW = $clog2(MD_TIMEOUT);

  issue_state_e state_q, state_d;
  logic [CW-1:0] md_cnt_q;
  logic          md_err_q;

  stage_occ_t exe_occ, mem_occ;
  logic [NUM_SRC-1:0][4:0] src_rs;
  logic [NUM_SRC-1:0]      src_en;
  logic [NUM_SRC-1:0][1:0] src_sel;
  logic [NUM_SRC-1:0]      src_unres;

  logic md_op, fl_op, issue_ok, md_tmo;

  assign exe_occ = '{vld: exe_valid, rd_en: exe_rd_en, fwd: exe_fwd, rd: exe_rd};
  assign mem_occ = '{vld: mem_valid, rd_en: mem_rd_en, fwd: mem_fwd, rd: mem_rd};

  assign src_rs = {id_pack.rs2, id_pack.rs1};
  assign src_en = {id_pack.rs2_en, id_pack.rs1_en};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_fwd_unit #(.FWD_EN(FWD_EN)) u_hz (
      .rs      (src_rs[i]),
      .rs_en   (src_en[i]),
      .exe     (exe_occ),
      .mem     (mem_occ),
      .fwd_sel (src_sel[i]),
      .unres   (src_unres[i])
    );
  end

  assign md_op  = id_pack.mul_en | id_pack.div_en;
  assign fl_op  = id_pack.fence_i | id_pack.flush_pipe;
  // Illegal instructions go down as trap bubbles regardless of hazards.
  assign issue_ok = id_valid && exe_ready && (id_illegal || !(|src_unres));
  assign md_tmo   = (md_cnt_q == CW'(MD_TIMEOUT - 1));

  // State register, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter sits at zero outside MD_BUSY so every entry starts clean.
      if (state_q == MD_BUSY) md_cnt_q <= md_cnt_q + 1'b1;
      else                    md_cnt_q <= '0;
      // A result arriving on the timeout cycle still counts as success.
      if (state_q == MD_BUSY && !md_done && md_tmo) md_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue_ok && !id_illegal) begin
          if (md_op)      state_d = MD_BUSY;
          else if (fl_op) state_d = DRAIN;
        end
      end
      MD_BUSY: if (md_done || md_tmo)        state_d = IDLE;
      DRAIN:   if (!exe_valid && !mem_valid) state_d = FLUSH;
      FLUSH:                                 state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so a still-present decoder
  // instruction cannot leak an issue or start pulse during reset.
  always_comb begin
    issue_valid = 1'b0;
    id_stall    = 1'b0;
    md_start    = 1'b0;
    flush_req   = 1'b0;
    fwd_rs1     = FWD_RF;
    fwd_rs2     = FWD_RF;
    md_err      = md_err_q;
    if (rst_n) begin
      fwd_rs1 = src_sel[0];
      fwd_rs2 = src_sel[1];
      unique case (state_q)
        IDLE: begin
          issue_valid = issue_ok;
          md_start    = issue_ok && !id_illegal && md_op;
          id_stall    = id_valid && !issue_ok;
        end
        MD_BUSY, DRAIN: id_stall = 1'b1;
        FLUSH: begin
          id_stall  = 1'b1;
          flush_req = 1'b1;
        end
        default: id_stall = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic id_valid, id_illegal, exe_valid, exe_rd_en, exe_fwd;
  logic mem_valid, mem_rd_en, mem_fwd, exe_ready, md_done;
  logic [4:0] exe_rd, mem_rd;
  decode_pack id_pack;

  // index 0: FWD_EN=1, MD_TIMEOUT=64 ; index 1: FWD_EN=0, MD_TIMEOUT=16
  logic [1:0] iv, st, ms, fr, er;
  logic [1:0][1:0] f1, f2;

  issue_ctrl #(.FWD_EN(1'b1), .MD_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pack(id_pack),
    .id_illegal(id_illegal), .exe_valid(exe_valid), .exe_rd_en(exe_rd_en),
    .exe_fwd(exe_fwd), .exe_rd(exe_rd), .mem_valid(mem_valid),
    .mem_rd_en(mem_rd_en), .mem_fwd(mem_fwd), .mem_rd(mem_rd),
    .exe_ready(exe_ready), .md_done(md_done), .issue_valid(iv[0]),
    .id_stall(st[0]), .fwd_rs1(f1[0]), .fwd_rs2(f2[0]), .md_start(ms[0]),
    .flush_req(fr[0]), .md_err(er[0]));

  issue_ctrl #(.FWD_EN(1'b0), .MD_TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pack(id_pack),
    .id_illegal(id_illegal), .exe_valid(exe_valid), .exe_rd_en(exe_rd_en),
    .exe_fwd(exe_fwd), .exe_rd(exe_rd), .mem_valid(mem_valid),
    .mem_rd_en(mem_rd_en), .mem_fwd(mem_fwd), .mem_rd(mem_rd),
    .exe_ready(exe_ready), .md_done(md_done), .issue_valid(iv[1]),
    .id_stall(st[1]), .fwd_rs1(f1[1]), .fwd_rs2(f2[1]), .md_start(ms[1]),
    .flush_req(fr[1]), .md_err(er[1]));

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  bit m_busy[2], m_drain[2], m_flush[2], m_err[2];
  int m_cnt[2];

  function automatic int to_of(int k);
    return (k == 0) ? 64 : 16;
  endfunction

  function automatic void hz(input bit fe, input logic [4:0] rs, input logic en,
                             output logic [1:0] sel, output bit unres);
    sel = 2'd0;
    unres = 1'b0;
    if (en && rs != 5'd0) begin
      if (exe_valid && exe_rd_en && exe_rd == rs) begin
        if (fe && exe_fwd) sel = 2'd1; else unres = 1'b1;
      end else if (mem_valid && mem_rd_en && mem_rd == rs) begin
        if (fe && mem_fwd) sel = 2'd2; else unres = 1'b1;
      end
    end
  endfunction

  // {issue_valid, id_stall, md_start, flush_req, md_err, fwd_rs1, fwd_rs2}
  function automatic logic [8:0] expect_out(int k);
    logic [1:0] s1, s2;
    bit u1, u2, e_iv, e_st, e_ms, e_fr;
    if (!rst_n) return 9'd0;
    hz(k == 0, id_pack.rs1, id_pack.rs1_en, s1, u1);
    hz(k == 0, id_pack.rs2, id_pack.rs2_en, s2, u2);
    if (m_busy[k] || m_drain[k] || m_flush[k]) begin
      e_iv = 0; e_st = 1; e_ms = 0; e_fr = m_flush[k];
    end else begin
      e_iv = id_valid && exe_ready && (id_illegal || !(u1 || u2));
      e_ms = e_iv && !id_illegal && (id_pack.mul_en || id_pack.div_en);
      e_st = id_valid && !e_iv;
      e_fr = 0;
    end
    return {e_iv, e_st, e_ms, e_fr, m_err[k], s1, s2};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [8:0] o;
      o = expect_out(k);
      if (!rst_n) begin
        m_busy[k] = 0; m_drain[k] = 0; m_flush[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      end else if (m_busy[k]) begin
        if (md_done) m_busy[k] = 0;
        else if (m_cnt[k] == to_of(k) - 1) begin m_err[k] = 1; m_busy[k] = 0; end
        else m_cnt[k]++;
      end else if (m_drain[k]) begin
        if (!exe_valid && !mem_valid) begin m_drain[k] = 0; m_flush[k] = 1; end
      end else if (m_flush[k]) begin
        m_flush[k] = 0;
      end else if (o[8] && !id_illegal) begin
        if (id_pack.mul_en || id_pack.div_en) begin m_busy[k] = 1; m_cnt[k] = 0; end
        else if (id_pack.fence_i || id_pack.flush_pipe) m_drain[k] = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [8:0] e, got;
      e   = expect_out(k);
      got = {iv[k], st[k], ms[k], fr[k], er[k], f1[k], f2[k]};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL model_cmp[%0d] t=%0t got=%b want=%b", k, $time, got, e);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic decode_pack pk(input logic [4:0] r1, input logic [4:0] r2,
                                    input bit e1, input bit e2, input bit mul,
                                    input bit fi);
    decode_pack p;
    p = '0;
    p.rs1 = r1; p.rs2 = r2; p.rs1_en = e1; p.rs2_en = e2;
    p.mul_en = mul; p.fence_i = fi;
    return p;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_valid = 0; id_illegal = 0; id_pack = '0;
    exe_valid = 0; exe_rd_en = 0; exe_fwd = 0; exe_rd = 0;
    mem_valid = 0; mem_rd_en = 0; mem_fwd = 0; mem_rd = 0;
    exe_ready = 1; md_done = 0;
  endtask

  task automatic do_reset();
    cyc(); quiet(); rst_n = 0;
    cyc(); cyc(); rst_n = 1;
  endtask

  initial begin
    quiet();
    rst_n = 0;
    id_valid = 1; id_pack = pk(5'd1, 5'd2, 1, 1, 1, 0);  // held mul must not leak during reset
    #7;
    chk("reset_outs", {iv, st, ms, fr, er, f1, f2}, 0);
    cyc(); cyc(); quiet(); rst_n = 1;

    // EXE add x5 forwards to ID add x6,x5,x1
    cyc(); quiet();
    exe_valid = 1; exe_rd_en = 1; exe_fwd = 1; exe_rd = 5'd5;
    id_valid = 1; id_pack = pk(5'd5, 5'd1, 1, 1, 0, 0);
    #5;
    chk("fwd_exe_iv", iv[0], 1); chk("fwd_exe_f1", f1[0], 1); chk("fwd_exe_f2", f2[0], 0);
    chk("nofwd_stall", st[1], 1); chk("nofwd_iv", iv[1], 0);

    // load in EXE -> stall, then MEM forward
    cyc(); quiet();
    exe_valid = 1; exe_rd_en = 1; exe_fwd = 0; exe_rd = 5'd5;
    id_valid = 1; id_pack = pk(5'd2, 5'd5, 1, 1, 0, 0);
    #5;
    chk("ld_stall", st[0], 1); chk("ld_iv", iv[0], 0);
    cyc();
    exe_valid = 0; exe_rd_en = 0;
    mem_valid = 1; mem_rd_en = 1; mem_fwd = 1; mem_rd = 5'd5;
    #5;
    chk("ld_mem_iv", iv[0], 1); chk("ld_mem_f2", f2[0], 2); chk("ld_mem_nofwd", st[1], 1);
    cyc();
    mem_valid = 0;
    #5;
    chk("retired_nofwd_iv", iv[1], 1);

    // x0 never hazards
    cyc(); quiet();
    exe_valid = 1; exe_rd_en = 1; exe_fwd = 0; exe_rd = 5'd0;
    id_valid = 1; id_pack = pk(5'd0, 5'd3, 1, 1, 0, 0);
    #5;
    chk("x0_iv", iv, 2'b11); chk("x0_f1", f1[0], 0);

    // mul with md_done 5 cycles later
    cyc(); quiet();
    id_valid = 1; id_pack = pk(5'd1, 5'd2, 1, 1, 1, 0);
    #5;
    chk("mul_start", ms[0], 1); chk("mul_iv", iv[0], 1);
    cyc(); id_pack = pk(5'd1, 5'd2, 1, 1, 0, 0);
    #5;
    chk("mul_busy_st", st[0], 1); chk("mul_busy_ms", ms[0], 0);
    for (int i = 2; i <= 4; i++) cyc();
    cyc(); md_done = 1;
    #5;
    chk("mul_done_st", st[0], 1);
    cyc(); md_done = 0;
    #5;
    chk("mul_next_iv", iv[0], 1); chk("mul_next_ms", ms[0], 0);

    // md_done on the timeout cycle of dut0 (16): no error
    do_reset();
    id_valid = 1; id_pack = pk(5'd1, 5'd2, 1, 1, 1, 0);
    cyc(); id_pack = '0; id_valid = 1;
    for (int i = 2; i <= 16; i++) cyc();
    md_done = 1;
    cyc(); md_done = 0;
    #5;
    chk("tmo_tie_err", er[1], 0); chk("tmo_tie_iv", iv[1], 1);

    // md_done withheld: timeout after 64 busy cycles on dut
    do_reset();
    id_valid = 1; id_pack = pk(5'd1, 5'd2, 1, 1, 1, 0);
    cyc(); id_pack = '0;
    for (int i = 2; i <= 64; i++) cyc();
    #5;
    chk("tmo_pre_err", er[0], 0); chk("tmo_pre_st", st[0], 1); chk("tmo_dut0_err", er[1], 1);
    cyc();
    #5;
    chk("tmo_err", er[0], 1); chk("tmo_idle_iv", iv[0], 1);

    // fence.i with EXE/MEM occupied for 2 cycles
    do_reset();
    exe_valid = 1; mem_valid = 1;
    id_valid = 1; id_pack = pk(5'd0, 5'd0, 0, 0, 0, 1);
    #5;
    chk("fence_iv", iv[0], 1);
    cyc(); id_pack = '0;
    #5;
    chk("drain1_st", st[0], 1); chk("drain1_fr", fr[0], 0);
    cyc(); exe_valid = 0; mem_valid = 0;
    #5;
    chk("drain2_fr", fr[0], 0);
    cyc();
    #5;
    chk("flush_fr", fr[0], 1); chk("flush_st", st[0], 1); chk("flush_ms", ms[0], 0);
    cyc();
    #5;
    chk("post_flush_fr", fr[0], 0); chk("post_flush_iv", iv[0], 1);

    // reset dropped mid MD_BUSY, md_done after release
    do_reset();
    id_valid = 1; id_pack = pk(5'd1, 5'd2, 1, 1, 1, 0);
    cyc(); id_pack = pk(5'd1, 5'd2, 1, 1, 0, 0);
    cyc();
    cyc(); rst_n = 0;
    #5;
    chk("rst_mid_outs", {iv, st, ms, fr, er}, 0);
    cyc();
    cyc(); rst_n = 1; md_done = 1;
    #5;
    chk("rst_rel_iv", iv[0], 1); chk("rst_rel_ms", ms, 0); chk("rst_rel_fr", fr, 0);
    cyc(); md_done = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n      = ($urandom_range(0, 299) != 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_illegal = ($urandom_range(0, 15) == 0);
      id_pack.rs1 = 5'($urandom_range(0, 7));
      id_pack.rs2 = 5'($urandom_range(0, 7));
      id_pack.rs1_en = 1'($urandom_range(0, 1));
      id_pack.rs2_en = 1'($urandom_range(0, 1));
      id_pack.mul_en = ($urandom_range(0, 11) == 0);
      id_pack.div_en = ($urandom_range(0, 11) == 0);
      id_pack.fence_i = ($urandom_range(0, 15) == 0);
      id_pack.flush_pipe = ($urandom_range(0, 15) == 0);
      exe_valid = 1'($urandom_range(0, 1)); exe_rd_en = 1'($urandom_range(0, 1));
      exe_fwd = 1'($urandom_range(0, 1)); exe_rd = 5'($urandom_range(0, 7));
      mem_valid = 1'($urandom_range(0, 1)); mem_rd_en = 1'($urandom_range(0, 1));
      mem_fwd = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 7));
      exe_ready = ($urandom_range(0, 3) != 0);
      md_done = ($urandom_range(0, 9) == 0);
    end

    cyc(); quiet(); rst_n = 1;
    cyc();
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
